bus_timer_resp: RTL and testbench
=================================

// Module: bus_timer_resp
// PURPOSE
//  Memory-mapped 16-bit down-counter timer that acts as a responder on the 65C02 CPU bus.
//  - Decodes AD against BASE.
//  - Accepts writes (WE=1) and returns read data on DI in the cycle after acceptance.
//  - Stretches accesses with WAIT wait states by pulling RDY low.
//  - Raises IRQ on underflow.
//  Sits beside RAM/ROM on the CPU bus. Its RDY and IRQ feed the CPU RDY and IRQ inputs.
// PARAMETERS
//  BASE      16'hFE00  base address; block decodes BASE..BASE+7 (AD[15:3]==BASE[15:3])
//  WAIT      0         wait states per selected access, 0..3
//  PRESCALE  1         clk cycles per counter tick, 1..256
// PORTS
//  clk   in   1   CPU clock
//  RST   in   1   reset, asynchronous, active-high
//  AD    in   16  CPU address bus (combinatorial from CPU)
//  DO    in   8   CPU write data (CPU DO)
//  WE    in   1   CPU write enable
//  DI    out  8   read data to CPU DI, registered
//  RDY   out  1   ready to CPU; 0 = wait state
//  IRQ   out  1   interrupt request, active-high, level
// BEHAVIOUR
//  Reset (async, RST=1):
//   - DI=0, RDY=1, IRQ=0
//   - CNT=16'hFFFF, RLD=16'hFFFF, CTRL=0, STAT=0, wcnt=0, prescaler=0, snapshot=0
//  Register map (offset = AD[2:0]):
//   0 CNT_LO   read: CNT[7:0]; write: CNT[7:0]
//   1 CNT_HI   read: CNT[15:8] (or snapshot, see CONFIGURATION); write: CNT[15:8]
//   2 RLD_LO   read/write RLD[7:0]
//   3 RLD_HI   read/write RLD[15:8]
//   4 CTRL     bit0 EN, bit1 AUTO (auto-reload), bit2 IE; bits7:3 read 0
//   5 STAT     bit0 EXP; write 1 to bit0 clears it; other bits read 0
//   6,7        read 8'h00; writes ignored
//  Access handshake:
//   - sel = (AD[15:3]==BASE[15:3]).
//   - RDY = !(sel && wcnt!=WAIT); combinational from AD and wcnt.
//   - sel && wcnt<WAIT: wcnt increments each clk; CPU is frozen with AD held.
//   - sel && wcnt==WAIT: access accepted at that posedge; wcnt returns to 0.
//   - !sel: wcnt forced to 0 and RDY=1.
//   - WAIT=0: every selected cycle is accepted immediately and RDY stays 1.
//  Accepted write: register updated at the accepting edge.
//  Accepted read: DI loaded with register value at the accepting edge and held until the next accepted read.
//   Latency: data valid in the cycle after acceptance.
//  Counter:
//   - A tick occurs every PRESCALE clks while EN=1; prescaler is cleared while EN=0.
//   - On tick with CNT!=0: CNT <= CNT-1.
//   - On tick with CNT==0: EXP <= 1. If AUTO=1, CNT <= RLD. If AUTO=0, CNT stays 0 and EN <= 0.
//   - Wrap: 0 is never decremented to FFFF.
//  IRQ = EXP & IE; both are registers, so IRQ has no combinational path from the bus.
//  Simultaneous events:
//   - CPU write to CNT_LO/HI on a tick edge: write wins and that tick is dropped.
//   - STAT clear on the same edge as an underflow: set wins (EXP=1).
//   - CTRL write on an underflow edge: written EN/AUTO take effect; the underflow still sets EXP.
//  Reset mid-access: RDY returns to 1 immediately; a pending access is abandoned with no register update.
// CONFIGURATION
//  TIMER_LATCH_EN defined:
//   - An accepted read of CNT_LO also copies CNT[15:8] into snapshot.
//   - CNT_HI reads return snapshot, giving an atomic 16-bit read as LO then HI.
//  TIMER_LATCH_EN undefined:
//   - No snapshot register; CNT_HI reads return live CNT[15:8].
// TESTING
//  1. Reset: RST pulse mid-run -> DI=00, RDY=1, IRQ=0; read CNT_LO/HI -> FF,FF; CTRL -> 00.
//  2. WAIT=2, read RLD_LO at FE02 -> RDY low exactly 2 cycles, then accepted; DI=FF on the following cycle.
//     Repeat with WAIT=0 -> RDY never low.
//  3. PRESCALE=1: write CNT=0003, CTRL=03 (EN|AUTO), RLD=0005
//     -> CNT reads 2,1,0, then EXP=1, CNT=5; IRQ stays 0 (IE=0).
//  4. Write CTRL=05 (EN|IE, AUTO=0), CNT=0001
//     -> after 2 ticks EXP=1, IRQ=1, CTRL reads 04 (EN cleared), CNT holds 0.
//     Write STAT=01 -> IRQ=0 next cycle.
//  5. Force STAT=01 write on the underflow edge -> EXP remains 1.
//     Force CNT_LO write on a tick edge -> written value held, no decrement that edge.
//  6. TIMER_LATCH_EN: CNT=0100 counting; read LO (00), wait 1 tick, read HI -> 01 with macro, 00 without.

Source files
------------

// File: rtl/bus_timer_resp.sv
// bus_timer_resp: 16-bit memory-mapped down-counter timer responding on a 65C02 CPU bus.
// Optional macro TIMER_LATCH_EN: CNT_LO reads latch CNT[15:8] so LO-then-HI reads are atomic.
module bus_timer_resp #(
  parameter logic [15:0] BASE     = 16'hFE00,
  parameter int unsigned WAIT     = 0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AD,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic        IRQ
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DAT_W = 8;
  localparam int unsigned WC_W  = 2;
  localparam int unsigned PS_W  = 8;
  localparam logic [WC_W-1:0] WAIT_L  = WC_W'(WAIT);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rld_q, rld_d;
  logic             en_q, en_d;
  logic             auto_q, auto_d;
  logic             ie_q, ie_d;
  logic             exp_q, exp_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [PS_W-1:0]  presc_q, presc_d;
  logic [DAT_W-1:0] di_q, di_d;
  logic [DAT_W-1:0] rd_data;
  logic [DAT_W-1:0] cnt_hi_rd;

  logic       sel;
  logic       accept;
  logic       wr;
  logic       rd;
  logic       cnt_wr;
  logic       tick;
  logic       uflow;
  logic [2:0] off;

  assign sel    = (AD[15:3] == BASE[15:3]);
  assign off    = AD[2:0];
  assign accept = sel && (wcnt_q == WAIT_L);
  assign wr     = accept && WE;
  assign rd     = accept && !WE;
  assign cnt_wr = wr && (off == 3'd0 || off == 3'd1);
  assign tick   = en_q && (presc_q == PS_LAST);

  // Reset holds RDY high so an access in progress is released at once.
  assign RDY = RST || !(sel && (wcnt_q != WAIT_L));
  assign IRQ = exp_q && ie_q;
  assign DI  = di_q;

`ifdef TIMER_LATCH_EN
  logic [DAT_W-1:0] snap_q, snap_d;

  always_comb begin
    snap_d = snap_q;
    if (rd && off == 3'd0) snap_d = cnt_q[15:8];
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) snap_q <= '0;
    else     snap_q <= snap_d;
  end

  assign cnt_hi_rd = snap_q;
`else
  assign cnt_hi_rd = cnt_q[15:8];
`endif

  // Register read mux, sampled into DI at the accepting edge.
  always_comb begin
    rd_data = '0;
    case (off)
      3'd0:    rd_data = cnt_q[7:0];
      3'd1:    rd_data = cnt_hi_rd;
      3'd2:    rd_data = rld_q[7:0];
      3'd3:    rd_data = rld_q[15:8];
      3'd4:    rd_data = {5'b0, ie_q, auto_q, en_q};
      3'd5:    rd_data = {7'b0, exp_q};
      default: rd_data = '0;
    endcase
  end

  // Wait-state counter and read-data capture.
  always_comb begin
    wcnt_d = '0;
    di_d   = di_q;
    if (sel && wcnt_q < WAIT_L) wcnt_d = wcnt_q + 2'd1;
    if (rd) di_d = rd_data;
  end

  // Prescaler, counter and CPU register writes; bus writes to CNT drop a coincident tick.
  always_comb begin
    presc_d = presc_q + 8'd1;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    en_d    = en_q;
    auto_d  = auto_q;
    ie_d    = ie_q;
    exp_d   = exp_q;
    uflow   = 1'b0;

    if (!en_q || tick) presc_d = '0;

    if (tick && !cnt_wr) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 16'd1;
      end else begin
        uflow = 1'b1;
        if (auto_q) cnt_d = rld_q;
        else        en_d  = 1'b0;
      end
    end

    if (wr) begin
      case (off)
        3'd0: cnt_d[7:0]  = DO;
        3'd1: cnt_d[15:8] = DO;
        3'd2: rld_d[7:0]  = DO;
        3'd3: rld_d[15:8] = DO;
        3'd4: begin
          en_d   = DO[0];
          auto_d = DO[1];
          ie_d   = DO[2];
        end
        3'd5: if (DO[0]) exp_d = 1'b0;
        default: ;
      endcase
    end

    if (uflow) exp_d = 1'b1;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt_q   <= 16'hFFFF;
      rld_q   <= 16'hFFFF;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      wcnt_q  <= '0;
      presc_q <= '0;
      di_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      exp_q   <= exp_d;
      wcnt_q  <= wcnt_d;
      presc_q <= presc_d;
      di_q    <= di_d;
    end
  end

endmodule

// File: tb/tb_bus_timer_resp.sv
// Testbench for bus_timer_resp: randomized CPU bus traffic checked against a behavioural timer model.
module tb_bus_timer_resp;

  localparam logic [15:0] BASE  = 16'hFE00;
  localparam int          WAITS = 2;
  localparam int          PRESC = 3;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] AD;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        RDY;
  logic        IRQ;

  bus_timer_resp #(.BASE(BASE), .WAIT(WAITS), .PRESCALE(PRESC)) dut (
    .clk(clk), .RST(RST), .AD(AD), .DO(DO), .WE(WE), .DI(DI), .RDY(RDY), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Behavioural timer state.
  int m_cnt, m_rld, m_snap, m_stall, m_presc;
  bit m_en, m_auto, m_ie, m_exp;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 'hFFFF; m_rld = 'hFFFF; m_snap = 0; m_stall = 0; m_presc = 0;
    m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
  endtask

  function automatic logic [7:0] read_val(input int off);
    case (off)
      0: return 8'(m_cnt);
`ifdef TIMER_LATCH_EN
      1: return 8'(m_snap);
`else
      1: return 8'(m_cnt >> 8);
`endif
      2: return 8'(m_rld);
      3: return 8'(m_rld >> 8);
      4: return 8'({m_ie, m_auto, m_en});
      5: return 8'(m_exp);
      default: return 8'h00;
    endcase
  endfunction

  // Effect of one clock edge given what the CPU presented during the cycle.
  task automatic model_edge(input bit sel, input bit acc, input bit we, input int off, input logic [7:0] d);
    bit tick, cw, uf, nen, nexp;
    int nc;
    m_stall = (sel && !acc) ? m_stall + 1 : 0;
    tick = 0;
    if (m_en) begin
      m_presc++;
      if (m_presc == PRESC) begin tick = 1; m_presc = 0; end
    end else m_presc = 0;
    if (acc && !we) begin
      exp_q.push_back(read_val(off));
      if (off == 0) m_snap = m_cnt >> 8;
    end
    cw = acc && we && off < 2;
    nc = m_cnt; nen = m_en; nexp = m_exp; uf = 0;
    if (tick && !cw) begin
      if (m_cnt > 0) nc = m_cnt - 1;
      else begin
        uf = 1; nexp = 1;
        if (m_auto) nc = m_rld; else nen = 0;
      end
    end
    if (acc && we) begin
      case (off)
        0: nc = (nc & 'hFF00) | int'(d);
        1: nc = (nc & 'h00FF) | (int'(d) << 8);
        2: m_rld = (m_rld & 'hFF00) | int'(d);
        3: m_rld = (m_rld & 'h00FF) | (int'(d) << 8);
        4: begin nen = d[0]; m_auto = d[1]; m_ie = d[2]; end
        5: if (d[0] && !uf) nexp = 0;
        default: ;
      endcase
    end
    m_cnt = nc; m_en = nen; m_exp = nexp;
  endtask

  task automatic cycle(input logic [15:0] a, input bit we, input logic [7:0] d, output bit acc);
    bit sel;
    @(negedge clk); #1;
    AD = a; WE = we; DO = d;
    #1;
    sel = (a[15:3] == BASE[15:3]);
    acc = sel && (m_stall == WAITS);
    check("rdy", 16'(RDY), 16'(!(sel && !acc)));
    check("irq", 16'(IRQ), 16'(m_exp && m_ie));
    model_edge(sel, acc, we, int'(a[2:0]), d);
  endtask

  task automatic access(input logic [15:0] a, input bit we, input logic [7:0] d);
    bit acc;
    for (int n = 0; n < 8; n++) begin
      cycle(a, we, d, acc);
      if (acc || a[15:3] != BASE[15:3]) return;
    end
    check("access_bound", 16'd0, 16'd1);
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    access(BASE + 16'(off), 1'b1, d);
  endtask

  task automatic rd(input int off);
    access(BASE + 16'(off), 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(16'h0000, 1'b0, 8'h00, acc);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    RST = 1'b1;
    #1;
    check("reset_rdy", 16'(RDY), 16'd1);
    check("reset_irq", 16'(IRQ), 16'd0);
    check("reset_di", 16'(DI), 16'd0);
    AD = 16'h0000; WE = 1'b0;
    @(negedge clk); #1;
    RST = 1'b0;
    model_reset();
  endtask

  // Read-data monitor: a read accepted this cycle must show its value on DI next cycle.
  initial begin
    bit pend = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk); #3;
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL read_data unexpected DI=%h with no read outstanding", DI);
        end else begin
          e = exp_q.pop_front();
          check("read_data", 16'(DI), 16'(e));
        end
      end
      pend = (AD[15:3] == BASE[15:3]) && RDY && !WE && !RST;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    RST = 1'b1; AD = 16'h0000; WE = 1'b0; DO = 8'h00;
    model_reset();
    #12;
    check("por_di", 16'(DI), 16'd0);
    check("por_rdy", 16'(RDY), 16'd1);
    check("por_irq", 16'(IRQ), 16'd0);
    @(negedge clk); #1;
    RST = 1'b0;

    // Reset values and wait-state handshake.
    rd(0); rd(1); rd(4); rd(2); rd(6);
    idle(2);

    // Auto-reload run, IE off.
    wr(2, 8'h05); wr(3, 8'h00); wr(0, 8'h03); wr(1, 8'h00); wr(4, 8'h03);
    for (int i = 0; i < 10; i++) begin rd(0); rd(5); end
    wr(4, 8'h00); wr(5, 8'h01);

    // One-shot with IRQ enabled.
    wr(0, 8'h01); wr(1, 8'h00); wr(4, 8'h05);
    idle(12);
    rd(4); rd(0); rd(5);
    wr(5, 8'h01);
    idle(2);

    // Sweep bus-write phase against tick and underflow edges.
    for (int k = 0; k < 5; k++) begin
      wr(2, 8'h00); wr(3, 8'h00); wr(0, 8'h00); wr(1, 8'h00); wr(4, 8'h07);
      idle(k); wr(5, 8'h01); rd(5);
      idle(k); wr(0, 8'h40); rd(0);
      wr(4, 8'h00); wr(5, 8'h01);
    end

    // LO then HI read across a tick.
    wr(0, 8'h00); wr(1, 8'h01); wr(4, 8'h01);
    rd(0); idle(PRESC + 1); rd(1);
    wr(4, 8'h00);
    idle(2);

    // Reset in the middle of a stalled access, then after traffic.
    cycle(BASE + 16'd2, 1'b0, 8'h00, acc);
    do_reset();
    rd(0); rd(1); rd(4);
    idle(1);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int r, off;
      logic [7:0] d;
      bit w;
      r = int'($urandom_range(0, 9));
      if (r == 0) idle(int'($urandom_range(0, 3)));
      else if (r == 1) access(16'($urandom_range(0, 16'h7FFF)), 1'($urandom_range(0, 1)), 8'($urandom));
      else begin
        off = int'($urandom_range(0, 7));
        w = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        if (off < 2) d = 8'($urandom_range(0, 3));
        if (off == 4 && $urandom_range(0, 3) != 0) d = d | 8'h01;
        access(BASE + 16'(off), w, d);
      end
    end

    idle(3);
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
